// File: rtl/mem_stage_if.sv
// Memory-bus bundle between mem_stage (master) and a data memory (slave).
//
// Handshake: the master raises mem_req and holds mem_addr, mem_we, mem_wdata
// and mem_be stable until the slave answers with mem_ack. A transfer completes
// in the cycle mem_req && mem_ack are both high. mem_rdata is only meaningful
// in that cycle. mem_ack seen while mem_req is low carries no meaning.
interface mem_stage_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_be,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/mem_stage.sv
// Pipeline memory stage: issues one load/store at a time on the memory bus,
// aligns load data, passes non-memory results through, and reports
// misaligned/illegal accesses and bus timeouts as single-cycle result pulses.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               ex_mem_valid_inst,
    input  logic               ex_mem_rd_mem,
    input  logic               ex_mem_wr_mem,
    input  logic [2:0]         ex_mem_funct3,
    input  logic [31:0]        ex_mem_alu_result,
    input  logic [31:0]        ex_mem_rega,
    mem_stage_if.master        mem_bus,
    output logic               mem_busy,
    output logic [31:0]        mem_result_out,
    output logic               mem_valid_out,
    output logic               mem_misaligned_out,
    output logic               mem_timeout_out,
    output logic               dbg_state_o
);

    localparam int unsigned     CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [31:0]        addr_q, addr_d;
    logic               we_q, we_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [3:0]         be_q, be_d;
    logic [2:0]         funct3_q, funct3_d;
    logic [1:0]         lane_q, lane_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        result_q, result_d;
    logic               valid_q, valid_d;
    logic               misaligned_q, misaligned_d;
    logic               timeout_q, timeout_d;

    logic               mem_op;
    logic               f3_legal;
    logic               addr_ok;
    logic               start;
    logic [3:0]         be_new;
    logic [31:0]        wdata_new;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [31:0]        load_data;

    assign mem_op = ex_mem_rd_mem | ex_mem_wr_mem;
    assign start  = (state_q == S_IDLE) & ex_mem_valid_inst & mem_op & f3_legal & addr_ok;

    // Decode access size: legality, alignment, byte enables and replicated store data.
    always_comb begin
        f3_legal  = 1'b1;
        addr_ok   = 1'b1;
        be_new    = 4'b1111;
        wdata_new = ex_mem_rega;
        case (ex_mem_funct3)
            3'b000, 3'b100: addr_ok = 1'b1;
            3'b001, 3'b101: addr_ok = ~ex_mem_alu_result[0];
            3'b010:         addr_ok = (ex_mem_alu_result[1:0] == 2'b00);
            default:        f3_legal = 1'b0;
        endcase
        case (ex_mem_funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << ex_mem_alu_result[1:0];
                wdata_new = {4{ex_mem_rega[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {ex_mem_alu_result[1], 1'b0};
                wdata_new = {2{ex_mem_rega[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = ex_mem_rega;
            end
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it.
    always_comb begin
        lane_byte = 8'h00;
        case (lane_q)
            2'd0:    lane_byte = mem_bus.mem_rdata[7:0];
            2'd1:    lane_byte = mem_bus.mem_rdata[15:8];
            2'd2:    lane_byte = mem_bus.mem_rdata[23:16];
            default: lane_byte = mem_bus.mem_rdata[31:24];
        endcase
        lane_half = lane_q[1] ? mem_bus.mem_rdata[31:16] : mem_bus.mem_rdata[15:0];
        case (funct3_q)
            3'b000:  load_data = {{24{lane_byte[7]}}, lane_byte};
            3'b100:  load_data = {24'h000000, lane_byte};
            3'b001:  load_data = {{16{lane_half[15]}}, lane_half};
            3'b101:  load_data = {16'h0000, lane_half};
            default: load_data = mem_bus.mem_rdata;
        endcase
    end

    // Next-state and result logic; pulses default low, datapath defaults to hold.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        we_d         = we_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        funct3_d     = funct3_q;
        lane_d       = lane_q;
        cnt_d        = cnt_q;
        result_d     = result_q;
        valid_d      = 1'b0;
        misaligned_d = 1'b0;
        timeout_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    // Store wins when both rd and wr are set.
                    state_d  = S_ACCESS;
                    addr_d   = {ex_mem_alu_result[31:2], 2'b00};
                    we_d     = ex_mem_wr_mem;
                    wdata_d  = wdata_new;
                    be_d     = be_new;
                    funct3_d = ex_mem_funct3;
                    lane_d   = ex_mem_alu_result[1:0];
                    cnt_d    = '0;
                end else if (ex_mem_valid_inst && mem_op) begin
                    valid_d      = 1'b1;
                    misaligned_d = 1'b1;
                    result_d     = 32'h0000_0000;
                end else if (ex_mem_valid_inst) begin
                    valid_d  = 1'b1;
                    result_d = ex_mem_alu_result;
                end
            end
            S_ACCESS: begin
                if (mem_bus.mem_ack) begin
                    state_d  = S_IDLE;
                    valid_d  = 1'b1;
                    result_d = we_q ? 32'h0000_0000 : load_data;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = S_IDLE;
                    valid_d   = 1'b1;
                    timeout_d = 1'b1;
                    result_d  = 32'hBAAD_BEEF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset clears everything, aborting any access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            addr_q       <= 32'h0000_0000;
            we_q         <= 1'b0;
            wdata_q      <= 32'h0000_0000;
            be_q         <= 4'b0000;
            funct3_q     <= 3'b000;
            lane_q       <= 2'b00;
            cnt_q        <= '0;
            result_q     <= 32'h0000_0000;
            valid_q      <= 1'b0;
            misaligned_q <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            we_q         <= we_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            funct3_q     <= funct3_d;
            lane_q       <= lane_d;
            cnt_q        <= cnt_d;
            result_q     <= result_d;
            valid_q      <= valid_d;
            misaligned_q <= misaligned_d;
            timeout_q    <= timeout_d;
        end
    end

    assign mem_bus.mem_req   = (state_q == S_ACCESS);
    assign mem_bus.mem_we    = we_q;
    assign mem_bus.mem_addr  = addr_q;
    assign mem_bus.mem_wdata = wdata_q;
    assign mem_bus.mem_be    = be_q;

    assign mem_busy           = start | ((state_q == S_ACCESS) & ~mem_bus.mem_ack);
    assign mem_result_out     = result_q;
    assign mem_valid_out      = valid_q;
    assign mem_misaligned_out = misaligned_q;
    assign mem_timeout_out    = timeout_q;
    assign dbg_state_o        = (state_q == S_ACCESS);

endmodule

// File: tb/tb_mem_stage.sv
// Directed plus randomized bench for mem_stage, checked against a byte-level
// reference model of the load/store rules.
module tb_mem_stage;

    localparam int TMO = 16;

    logic        clk;
    logic        rst;
    logic        ex_mem_valid_inst;
    logic        ex_mem_rd_mem;
    logic        ex_mem_wr_mem;
    logic [2:0]  ex_mem_funct3;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_rega;
    logic        mem_busy;
    logic [31:0] mem_result_out;
    logic        mem_valid_out;
    logic        mem_misaligned_out;
    logic        mem_timeout_out;
    logic        dbg_state_o;

    mem_stage_if bus ();

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk                (clk),
        .rst                (rst),
        .ex_mem_valid_inst  (ex_mem_valid_inst),
        .ex_mem_rd_mem      (ex_mem_rd_mem),
        .ex_mem_wr_mem      (ex_mem_wr_mem),
        .ex_mem_funct3      (ex_mem_funct3),
        .ex_mem_alu_result  (ex_mem_alu_result),
        .ex_mem_rega        (ex_mem_rega),
        .mem_bus            (bus),
        .mem_busy           (mem_busy),
        .mem_result_out     (mem_result_out),
        .mem_valid_out      (mem_valid_out),
        .mem_misaligned_out (mem_misaligned_out),
        .mem_timeout_out    (mem_timeout_out),
        .dbg_state_o        (dbg_state_o)
    );

    int          n_checks;
    int          n_pass;
    logic [31:0] last_result;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed no finish, expected finish before 500000");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model ----------------
    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit legal_op(input logic [2:0] f3, input logic [31:0] a);
        int off;
        if (f3 == 3'b011 || f3 == 3'b110 || f3 == 3'b111) return 1'b0;
        off = int'(a[1:0]);
        return (off % nbytes(f3)) == 0;
    endfunction

    function automatic logic [3:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        logic [3:0] be;
        int off;
        int n;
        n   = nbytes(f3);
        off = int'(a[1:0]);
        be  = 4'b0000;
        for (int i = 0; i < 4; i++) if (i >= off && i < off + n) be[i] = 1'b1;
        return be;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] rg);
        logic [31:0] wd;
        int n;
        n = nbytes(f3);
        for (int i = 0; i < 4; i++) wd[8*i +: 8] = rg[8*(i % n) +: 8];
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] rd);
        logic [31:0] v;
        logic [31:0] mask;
        int n;
        n = nbytes(f3);
        v = rd >> (8 * int'(a[1:0]));
        if (n == 4) return v;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = v & mask;
        if (!f3[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    // Present one instruction, follow it to completion and check every cycle.
    // delay = ACCESS cycles without ack before ack; delay >= TMO never acks.
    task automatic do_instr(input bit v, input bit rd, input bit wr, input logic [2:0] f3,
                            input logic [31:0] a, input logic [31:0] rg, input int delay,
                            input logic [31:0] rdat);
        bit memop;
        logic [31:0] exp;
        memop = rd | wr;
        ex_mem_valid_inst = v;
        ex_mem_rd_mem     = rd;
        ex_mem_wr_mem     = wr;
        ex_mem_funct3     = f3;
        ex_mem_alu_result = a;
        ex_mem_rega       = rg;
        bus.mem_ack       = 1'b0;
        #1;
        if (!v) begin
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = $urandom;
            #1;
            chk("inv_busy", mem_busy, 0);
            tick();
            chk("inv_valid", mem_valid_out, 0);
            chk("inv_req", bus.mem_req, 0);
            chk("inv_hold", mem_result_out, last_result);
            bus.mem_ack = 1'b0;
        end else if (!memop || !legal_op(f3, a)) begin
            chk("nobus_busy", mem_busy, 0);
            tick();
            exp = memop ? 32'h0 : a;
            chk("nobus_valid", mem_valid_out, 1);
            chk("nobus_result", mem_result_out, exp);
            chk("nobus_misal", mem_misaligned_out, memop);
            chk("nobus_tmo", mem_timeout_out, 0);
            chk("nobus_req", bus.mem_req, 0);
            last_result = exp;
        end else begin
            chk("start_busy", mem_busy, 1);
            tick();
            for (int k = 0; k < TMO; k++) begin
                chk("acc_req", bus.mem_req, 1);
                chk("acc_addr", bus.mem_addr, a & 32'hFFFF_FFFC);
                chk("acc_we", bus.mem_we, wr);
                if (wr) begin
                    chk("acc_be", bus.mem_be, model_be(f3, a));
                    chk("acc_wdata", bus.mem_wdata, model_wdata(f3, rg));
                end
                if (k == 0) begin
                    chk("acc_state", dbg_state_o, 1);
                    chk("acc_novalid", mem_valid_out, 0);
                end
                if (k == delay) begin
                    bus.mem_ack   = 1'b1;
                    bus.mem_rdata = rdat;
                    #1;
                    chk("ack_busy", mem_busy, 0);
                    tick();
                    bus.mem_ack   = 1'b0;
                    bus.mem_rdata = $urandom;
                    exp = wr ? 32'h0 : model_load(f3, a, rdat);
                    chk("done_valid", mem_valid_out, 1);
                    chk("done_result", mem_result_out, exp);
                    chk("done_tmo", mem_timeout_out, 0);
                    chk("done_misal", mem_misaligned_out, 0);
                    chk("done_req", bus.mem_req, 0);
                    last_result = exp;
                    break;
                end
                bus.mem_rdata = $urandom;
                #1;
                chk("wait_busy", mem_busy, 1);
                tick();
                if (k == TMO - 1) begin
                    chk("tmo_valid", mem_valid_out, 1);
                    chk("tmo_flag", mem_timeout_out, 1);
                    chk("tmo_result", mem_result_out, 32'hBAAD_BEEF);
                    chk("tmo_req", bus.mem_req, 0);
                    last_result = 32'hBAAD_BEEF;
                end
            end
        end
        ex_mem_valid_inst = 1'b0;
    endtask

    logic [2:0] legal_f3 [5];

    initial begin
        bit          rd;
        bit          wr;
        bit          v;
        int          kind;
        int          dly;
        logic [2:0]  f3;
        logic [31:0] a;

        n_checks          = 0;
        n_pass            = 0;
        last_result       = 32'h0;
        legal_f3          = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        rst               = 1'b0;
        ex_mem_valid_inst = 1'b0;
        ex_mem_rd_mem     = 1'b0;
        ex_mem_wr_mem     = 1'b0;
        ex_mem_funct3     = 3'b000;
        ex_mem_alu_result = 32'h0;
        ex_mem_rega       = 32'h0;
        bus.mem_ack       = 1'b0;
        bus.mem_rdata     = 32'h0;

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.mem_req, 0);
        chk("rst_we", bus.mem_we, 0);
        chk("rst_addr", bus.mem_addr, 0);
        chk("rst_wdata", bus.mem_wdata, 0);
        chk("rst_be", bus.mem_be, 0);
        chk("rst_result", mem_result_out, 0);
        chk("rst_valid", mem_valid_out, 0);
        chk("rst_misal", mem_misaligned_out, 0);
        chk("rst_tmo", mem_timeout_out, 0);
        rst = 1'b1;
        tick();

        // LB from 0x1003, ack in second ACCESS cycle
        do_instr(1, 1, 0, 3'b000, 32'h0000_1003, 32'h0, 1, 32'h80FF_FFFF);
        // SH 0xABCD to 0x2002, immediate ack
        do_instr(1, 0, 1, 3'b001, 32'h0000_2002, 32'h0000_ABCD, 0, 32'h0);
        // LW misaligned
        do_instr(1, 1, 0, 3'b010, 32'h0000_3001, 32'h0, 0, 32'h0);
        // illegal funct3
        do_instr(1, 1, 0, 3'b011, 32'h0000_3000, 32'h0, 0, 32'h0);
        // load that never sees ack
        do_instr(1, 1, 0, 3'b010, 32'h0000_4000, 32'h0, TMO, 32'h0);
        // non-memory op, then back-to-back loads
        do_instr(1, 0, 0, 3'b000, 32'h1234_5678, 32'h0, 0, 32'h0);
        do_instr(1, 1, 0, 3'b010, 32'h0000_5000, 32'h0, 0, 32'hCAFE_F00D);
        do_instr(1, 1, 0, 3'b101, 32'h0000_5002, 32'h0, 0, 32'h8001_7FFF);
        // rd and wr both set behaves as a store; invalid slot ignores ack
        do_instr(1, 1, 1, 3'b000, 32'h0000_6001, 32'h0000_0055, 2, 32'hFFFF_FFFF);
        do_instr(0, 1, 0, 3'b010, 32'h0000_7000, 32'h0, 0, 32'h0);

        // randomized mix
        for (int t = 0; t < 60; t++) begin
            v    = ($urandom_range(0, 9) != 0);
            kind = int'($urandom_range(0, 3));
            rd   = (kind == 1) || (kind == 3);
            wr   = (kind == 2) || (kind == 3);
            if ($urandom_range(0, 3) != 0) f3 = legal_f3[$urandom_range(0, 4)];
            else                           f3 = 3'($urandom_range(0, 7));
            a    = $urandom;
            dly  = ($urandom_range(0, 14) == 0) ? TMO : int'($urandom_range(0, 4));
            do_instr(v, rd, wr, f3, a, $urandom, dly, $urandom);
        end

        // reset in the second ACCESS cycle, late ack afterwards
        ex_mem_valid_inst = 1'b1;
        ex_mem_rd_mem     = 1'b1;
        ex_mem_wr_mem     = 1'b0;
        ex_mem_funct3     = 3'b010;
        ex_mem_alu_result = 32'h0000_8000;
        #1;
        chk("rstacc_start", mem_busy, 1);
        tick();
        tick();
        chk("rstacc_req_pre", bus.mem_req, 1);
        rst = 1'b0;
        ex_mem_valid_inst = 1'b0;
        #1;
        chk("rstacc_req", bus.mem_req, 0);
        chk("rstacc_addr", bus.mem_addr, 0);
        chk("rstacc_valid", mem_valid_out, 0);
        tick();
        chk("rstacc_valid2", mem_valid_out, 0);
        rst           = 1'b1;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_0001;
        tick();
        bus.mem_ack = 1'b0;
        chk("late_ack_valid", mem_valid_out, 0);
        chk("late_ack_req", bus.mem_req, 0);
        chk("late_ack_result", mem_result_out, 0);
        last_result = 32'h0;
        do_instr(1, 0, 0, 3'b000, 32'h0BAD_F00D, 32'h0, 0, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
